// File: rtl/main_mod_pkg.sv
// rtl/main_mod_pkg.sv - shared width and operand type for the three-input minimum finder
package main_mod_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] operand_t;

endpackage

// File: rtl/main_mod_min2_reg.sv
// rtl/main_mod_min2_reg.sv - registered two-input unsigned minimum cell
module min2_reg
    import main_mod_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z
);

    logic [WIDTH-1:0] z_d;
    logic [WIDTH-1:0] z_q;

    always_comb begin
        z_d = (x < y) ? x : y;
    end

    // rst_n is active-high despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            z_q <= '0;
        end else begin
            z_q <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: rtl/main_mod.sv
// rtl/main_mod.sv - two-stage pipelined min(a, b, c) built from three min2_reg cells
module main_mod
    import main_mod_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d
);

    logic [WIDTH-1:0] m_ab;
    logic [WIDTH-1:0] m_ac;

    min2_reg #(.WIDTH(WIDTH)) u_ab (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (a),
        .y     (b),
        .z     (m_ab)
    );

    min2_reg #(.WIDTH(WIDTH)) u_ac (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (a),
        .y     (c),
        .z     (m_ac)
    );

    min2_reg #(.WIDTH(WIDTH)) u_out (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (m_ab),
        .y     (m_ac),
        .z     (d)
    );

endmodule

// File: tb/tb_main_mod.sv
// tb/tb_main_mod.sv - self-checking bench for main_mod: vector table, hand sequences, random vs model
module tb_main_mod;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;

    int checks;
    int errors;

    int pipe_q[$];
    int exp_d;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] vc;
        logic [7:0] vd;
    } vec_t;

    vec_t vecs[9];

    main_mod #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int min3(int x, int y, int z);
        int m;
        m = x;
        if (y < m) m = y;
        if (z < m) m = z;
        return m;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input int exp);
        checks++;
        if (act !== exp[7:0]) begin
            errors++;
            $display("FAIL %s: d=%0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a result becomes visible one edge after the edge that sampled it
    // into the pipeline; reset empties the pipeline to zeros.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            pipe_q = '{0};
            exp_d = 0;
        end else begin
            exp_d = pipe_q.pop_front();
            pipe_q.push_back(min3(int'(a), int'(b), int'(c)));
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] na, input logic [7:0] nb, input logic [7:0] nc);
        a = na;
        b = nb;
        c = nc;
    endtask

    initial begin
        int av[4];
        int ev[4];
        checks = 0;
        errors = 0;
        pipe_q = '{0};
        exp_d = 0;

        vecs[0] = '{8'd10,  8'd15,  8'd35,  8'd10};
        vecs[1] = '{8'd50,  8'd15,  8'd35,  8'd15};
        vecs[2] = '{8'd50,  8'd44,  8'd35,  8'd35};
        vecs[3] = '{8'd50,  8'd44,  8'd45,  8'd44};
        vecs[4] = '{8'd50,  8'd10,  8'd45,  8'd10};
        vecs[5] = '{8'd7,   8'd7,   8'd7,   8'd7};
        vecs[6] = '{8'd255, 8'd255, 8'd0,   8'd0};
        vecs[7] = '{8'd255, 8'd255, 8'd255, 8'd255};
        vecs[8] = '{8'd30,  8'd20,  8'd20,  8'd20};

        rst_n = 1'b1;
        drive(8'd10, 8'd15, 8'd35);
        #1;
        check("reset_initial", d, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", d, 0);
        end

        rst_n = 1'b0;
        tick();
        check("release_edge1", d, 0);
        tick();
        check("release_edge2", d, 10);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].va, vecs[i].vb, vecs[i].vc);
            tick();
            tick();
            check($sformatf("vec%0d", i), d, int'(vecs[i].vd));
            check($sformatf("vec%0d_model", i), d, exp_d);
        end

        av = '{5, 3, 200, 1};
        ev = '{5, 3, 100, 1};
        drive(8'd100, 8'd100, 8'd100);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) a = av[i][7:0];
            tick();
            if (i >= 1) check($sformatf("pipe%0d", i - 1), d, ev[i - 1]);
        end

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: drive(8'($urandom), 8'($urandom), 8'($urandom));
                1: begin
                    a = 8'($urandom_range(0, 3));
                    b = 8'($urandom_range(0, 3));
                    c = 8'($urandom_range(0, 3));
                end
                2: begin
                    a = $urandom_range(0, 1) ? 8'hff : 8'h00;
                    b = $urandom_range(0, 1) ? 8'hff : 8'h00;
                    c = 8'($urandom);
                end
                default: begin
                    a = 8'($urandom);
                    b = a;
                    c = 8'($urandom);
                end
            endcase
            if (n == 150 || n == 220) begin
                #2;
                rst_n = 1'b1;
                #1;
                check("midstream_reset", d, 0);
                rst_n = 1'b0;
                pipe_q = '{0};
                exp_d = 0;
                tick();
                check("after_reset_edge1", d, 0);
                tick();
                check("after_reset_edge2", d, min3(int'(a), int'(b), int'(c)));
            end else begin
                tick();
                check("random", d, exp_d);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
